// File: rtl/dsss_pkg.sv
// ---------------------------------------------------------------------------
// dsss_pkg
// Shared types and helpers for the DSSS spreader / symbol mapper.
//   mode_e     : per-word modulation (BPSK carries 1 bit/symbol, QPSK 2)
//   state_e    : symbol engine state
//   lfsr_next  : one Fibonacci step of a left-shifting PN register
// ---------------------------------------------------------------------------
package dsss_pkg;

  // Widest PN register the helper supports.
  localparam int LFSR_MAX_W = 32;

  typedef enum logic {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Shift left by one and append the parity of the tapped bits. The result
  // is left unmasked; the caller truncates it to its own register width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] value,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return (value << 1) | LFSR_MAX_W'(^(value & taps));
  endfunction

endpackage

// File: rtl/dsss_chip_mapper_pn_lfsr.sv
// ---------------------------------------------------------------------------
// pn_lfsr
// PN chip generator, reseeded at every symbol start.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start of a symbol; the current chip is taken from SEED
//   step       : a chip is consumed this cycle; advance the register
//   chip       : chip for this cycle (MSB of the seed on load, else of
//                the running register)
// ---------------------------------------------------------------------------
module pn_lfsr
  import dsss_pkg::*;
#(
  parameter int           W    = 7,
  parameter logic [W-1:0] TAPS = 7'h60,
  parameter logic [W-1:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic chip
);

  if (W < 2 || W > LFSR_MAX_W) begin : g_chk_w
    $error("pn_lfsr: W out of range");
  end

  logic [W-1:0] lfsr_q;
  logic [W-1:0] cur;

  // Load and first step can share a cycle, so the chip is drawn from the
  // seed directly rather than waiting a cycle for the register.
  assign cur  = load ? SEED : lfsr_q;
  assign chip = cur[W-1];

  // NOTE: sequential state uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= W'(lfsr_next(LFSR_MAX_W'(cur), LFSR_MAX_W'(TAPS)));
    end else if (load) begin
      lfsr_q <= SEED;
    end
  end

endmodule

// File: rtl/dsss_chip_mapper.sv
// ---------------------------------------------------------------------------
// dsss_chip_mapper
// Direct-sequence spreader and BPSK/QPSK mapper. Words enter through a
// one-word buffer, are serialised MSB first, each symbol is spread by a
// reseeded PN sequence, and chips leave as signed {I, Q} samples paced by a
// free-running chip-rate counter.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data, i_valid  : input word and its valid
//   o_ready          : a word can be accepted this cycle
//   i_mode           : 0 = BPSK, 1 = QPSK, captured with each word
//   o_data           : {I, Q} sample, each SAMPLE_W bits signed
//   o_valid          : one-cycle sample strobe
//   o_underrun       : one-cycle pulse when the stream starves
//   o_busy           : a symbol is in flight or data is held
// ---------------------------------------------------------------------------
module dsss_chip_mapper
  import dsss_pkg::*;
#(
  parameter int                          DATA_W    = 8,
  parameter int                          SPREAD    = 24,
  parameter int                          CHIP_DIV  = 120,
  parameter int                          LFSR_W    = 7,
  parameter logic [LFSR_W-1:0]           LFSR_TAPS = 7'h60,
  parameter logic [LFSR_W-1:0]           LFSR_SEED = 7'h7F,
  parameter int                          SAMPLE_W  = 16,
  parameter logic signed [SAMPLE_W-1:0]  AMP       = 16'sd23170
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_mode,
  output logic [2*SAMPLE_W-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_underrun,
  output logic                  o_busy
);

  if (DATA_W < 2 || (DATA_W % 2) != 0) begin : g_chk_data_w
    $error("dsss_chip_mapper: DATA_W must be even");
  end
  if (SPREAD < 2 || SPREAD > (2 ** LFSR_W) - 1) begin : g_chk_spread
    $error("dsss_chip_mapper: SPREAD must lie in 2 .. 2**LFSR_W-1");
  end
  if (LFSR_SEED == '0) begin : g_chk_seed
    $error("dsss_chip_mapper: LFSR_SEED must be nonzero");
  end
  if (CHIP_DIV < 2) begin : g_chk_div
    $error("dsss_chip_mapper: CHIP_DIV must be at least 2");
  end

  localparam int TICK_W = $clog2(CHIP_DIV);
  localparam int CHIP_W = $clog2(SPREAD);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [TICK_W-1:0]          TICK_LAST = TICK_W'(CHIP_DIV - 1);
  localparam logic [CHIP_W-1:0]          CHIP_LAST = CHIP_W'(SPREAD - 1);
  localparam logic [CNT_W-1:0]           WORD_BITS = CNT_W'(DATA_W);
  localparam logic signed [SAMPLE_W-1:0] NEG_AMP   = -AMP;

  // Control state
  logic              ready_en;
  logic              buf_full;
  mode_e             buf_mode;
  logic [CNT_W-1:0]  sr_cnt;
  mode_e             sr_mode;
  state_e            state, state_d;
  logic [TICK_W-1:0] tick_cnt;
  logic [CHIP_W-1:0] chip_cnt;
  logic              sym_bi, sym_bq;
  mode_e             sym_mode;
  logic              last_emit;

  // Payload
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] sr_data;

  // Per-cycle decode
  logic              accept, sr_load, tick, avail;
  logic              emit, load_sym, underrun_d, chip;
  logic              cur_bi, cur_bq;
  mode_e             cur_mode;
  logic [CNT_W-1:0]  sym_bits;
  logic signed [SAMPLE_W-1:0] lane_i, lane_q;

  // ready_en keeps o_ready low in reset and for the first cycle after it.
  assign o_ready  = ready_en & ~buf_full;
  assign accept   = i_valid & o_ready;
  assign sr_load  = buf_full & (sr_cnt == '0);
  assign tick     = (tick_cnt == TICK_LAST);
  assign avail    = (sr_cnt != '0);
  assign sym_bits = (sr_mode == MODE_QPSK) ? CNT_W'(2) : CNT_W'(1);
  assign o_busy   = (state == ACTIVE) | avail | buf_full;

  // Symbol engine. A new symbol emits its first chip on the tick it loads,
  // which keeps samples back-to-back across symbol and word boundaries.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d    = state;
    emit       = 1'b0;
    load_sym   = 1'b0;
    underrun_d = 1'b0;
    cur_bi     = sym_bi;
    cur_bq     = sym_bq;
    cur_mode   = sym_mode;
    if (tick) begin
      case (state)
        ACTIVE: begin
          emit = 1'b1;
          if (chip_cnt == CHIP_LAST) state_d = IDLE;
        end
        default: begin
          if (avail) begin
            emit     = 1'b1;
            load_sym = 1'b1;
            cur_bi   = sr_data[DATA_W-1];
            cur_bq   = sr_data[DATA_W-2];
            cur_mode = sr_mode;
            state_d  = ACTIVE;
          end else begin
            underrun_d = last_emit;
          end
        end
      endcase
    end
  end

  // Chip mapping: both lanes share the chip; BPSK leaves Q at zero.
  always_comb begin
    lane_i = (cur_bi ^ chip) ? NEG_AMP : AMP;
    lane_q = '0;
    if (cur_mode == MODE_QPSK) lane_q = (cur_bq ^ chip) ? NEG_AMP : AMP;
  end

  pn_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_pn (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .load  (load_sym),
    .step  (emit),
    .chip  (chip)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_en   <= 1'b0;
      tick_cnt   <= '0;
      buf_full   <= 1'b0;
      buf_mode   <= MODE_BPSK;
      sr_cnt     <= '0;
      sr_mode    <= MODE_BPSK;
      chip_cnt   <= '0;
      sym_bi     <= 1'b0;
      sym_bq     <= 1'b0;
      sym_mode   <= MODE_BPSK;
      last_emit  <= 1'b0;
      o_valid    <= 1'b0;
      o_underrun <= 1'b0;
      o_data     <= '0;
    end else begin
      ready_en <= 1'b1;
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      buf_full <= accept | (buf_full & ~sr_load);
      if (accept) buf_mode <= mode_e'(i_mode);

      // sr_load needs an empty register and load_sym a non-empty one, so
      // the two never collide.
      if (sr_load) begin
        sr_cnt  <= WORD_BITS;
        sr_mode <= buf_mode;
      end else if (load_sym) begin
        sr_cnt  <= sr_cnt - sym_bits;
      end

      if (load_sym) begin
        sym_bi   <= cur_bi;
        sym_bq   <= cur_bq;
        sym_mode <= cur_mode;
        chip_cnt <= CHIP_W'(1);
      end else if (emit) begin
        chip_cnt <= chip_cnt + CHIP_W'(1);
      end

      if (tick) last_emit <= emit;
      o_valid    <= emit;
      o_underrun <= underrun_d;
      if (emit) o_data <= {lane_i, lane_q};
    end
  end

  // NOTE: payload registers have no reset; buf_full and sr_cnt qualify them.
  always_ff @(posedge i_clk) begin
    if (accept) buf_data <= i_data;
    if (sr_load)       sr_data <= buf_data;
    else if (load_sym) sr_data <= sr_data << sym_bits;
  end

endmodule
